// File: rtl/cl_tx_gen.sv
// Camera-link style video test-pattern source: two pixels per clock, frame/line/data valid
// framing with programmable blanking. Requires ADDR_WIDTH >= 4 for the checkerboard.
module cl_tx_gen #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 11
) (
  input  logic                   CCLK,
  input  logic                   RST,
  input  logic                   iENABLE,
  input  logic [ADDR_WIDTH-1:0]  iHSIZE,
  input  logic [ADDR_WIDTH-1:0]  iVSIZE,
  input  logic [ADDR_WIDTH-1:0]  iHBLANK,
  input  logic [ADDR_WIDTH-1:0]  iVBLANK,
  input  logic [1:0]             iPATTERN_SEL,
  input  logic [PIXEL_WIDTH-1:0] iCONST,
  output logic                   oVSYNC,
  output logic                   oHSYNC,
  output logic                   oDE,
  output logic [PIXEL_WIDTH-1:0] oDATA_L,
  output logic [PIXEL_WIDTH-1:0] oDATA_R,
  output logic                   oFRAME_DONE,
  output logic [ADDR_WIDTH-1:0]  oFRAME_CNT,
  output logic                   oBUSY
);

  typedef enum logic [1:0] {StIdle, StHblank, StActive, StVblank} state_e;
  typedef enum logic [1:0] {PatHRamp, PatVRamp, PatChecker, PatConst} pattern_e;

  localparam logic [ADDR_WIDTH:0] OneExt = (ADDR_WIDTH+1)'(1);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;

  // Frame configuration, frozen for the duration of a frame.
  logic [ADDR_WIDTH-1:0] hhalf_q, hhalf_d;
  logic [ADDR_WIDTH-1:0] vsize_q, vsize_d;
  logic [ADDR_WIDTH-1:0] hblank_q, hblank_d;
  logic [ADDR_WIDTH-1:0] vblank_q, vblank_d;
  pattern_e              pat_q, pat_d;

  logic                  sizes_ok;
  logic                  frame_start;
  logic                  hb_last, act_last, vb_last, row_last;
  logic [ADDR_WIDTH:0]   cnt_inc, row_inc;

  logic                   vsync_d, de_d, done_d, busy_d;
  logic [PIXEL_WIDTH-1:0] data_l_d, data_r_d;
  logic [ADDR_WIDTH-1:0]  fcnt_d;

  logic                   unused_hsize_lsb;

  assign unused_hsize_lsb = iHSIZE[0];

  assign sizes_ok = (iHSIZE[ADDR_WIDTH-1:1] != '0) && (iVSIZE != '0);

  // Widened compares: a zero blanking length behaves as one cycle, and no overflow at max.
  assign cnt_inc  = {1'b0, cnt_q} + OneExt;
  assign row_inc  = {1'b0, row_q} + OneExt;
  assign hb_last  = cnt_inc >= {1'b0, hblank_q};
  assign vb_last  = cnt_inc >= {1'b0, vblank_q};
  assign act_last = cnt_inc >= {1'b0, hhalf_q};
  assign row_last = row_inc >= {1'b0, vsize_q};

  // State register
  always_ff @(posedge CCLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (iENABLE && sizes_ok) state_d = StHblank;
      end
      StHblank: begin
        if (hb_last) state_d = StActive;
      end
      StActive: begin
        if (act_last) state_d = row_last ? StVblank : StHblank;
      end
      StVblank: begin
        if (vb_last) state_d = (iENABLE && sizes_ok) ? StHblank : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_start = (state_d == StHblank) &&
                       ((state_q == StIdle) || (state_q == StVblank));

  // Counters and configuration capture
  always_comb begin
    cnt_d    = cnt_q + ADDR_WIDTH'(1);
    col_d    = '0;
    row_d    = row_q;
    hhalf_d  = hhalf_q;
    vsize_d  = vsize_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    pat_d    = pat_q;

    if ((state_d != state_q) || (state_d == StIdle)) cnt_d = '0;

    if (state_d == StActive) begin
      col_d = (state_q == StActive) ? col_q + ADDR_WIDTH'(2) : '0;
    end

    if (frame_start) begin
      row_d    = '0;
      hhalf_d  = {1'b0, iHSIZE[ADDR_WIDTH-1:1]};
      vsize_d  = iVSIZE;
      hblank_d = iHBLANK;
      vblank_d = iVBLANK;
      pat_d    = pattern_e'(iPATTERN_SEL);
    end else if ((state_q == StActive) && (state_d == StHblank)) begin
      row_d = row_q + ADDR_WIDTH'(1);
    end
  end

  // Output logic: next values for the output registers, derived from the next state.
  always_comb begin
    vsync_d  = (state_d == StHblank) || (state_d == StActive);
    de_d     = (state_d == StActive);
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StActive) && (state_d == StVblank);
    fcnt_d   = oFRAME_CNT + ADDR_WIDTH'(done_d);
    data_l_d = '0;
    data_r_d = '0;
    if (de_d) begin
      unique case (pat_q)
        PatHRamp: begin
          data_l_d = PIXEL_WIDTH'(col_d);
          data_r_d = PIXEL_WIDTH'(col_d + ADDR_WIDTH'(1));
        end
        PatVRamp: begin
          data_l_d = PIXEL_WIDTH'(row_d);
          data_r_d = PIXEL_WIDTH'(row_d);
        end
        PatChecker: begin
          data_l_d = {PIXEL_WIDTH{col_d[3] ^ row_d[3]}};
          data_r_d = {PIXEL_WIDTH{col_d[3] ^ row_d[3]}};
        end
        PatConst: begin
          data_l_d = iCONST;
          data_r_d = iCONST;
        end
        default: begin
          data_l_d = '0;
          data_r_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CCLK) begin
    if (RST) begin
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hhalf_q     <= '0;
      vsize_q     <= '0;
      hblank_q    <= '0;
      vblank_q    <= '0;
      pat_q       <= PatHRamp;
      oVSYNC      <= 1'b0;
      oDE         <= 1'b0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_CNT  <= '0;
      oDATA_L     <= '0;
      oDATA_R     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hhalf_q     <= hhalf_d;
      vsize_q     <= vsize_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      pat_q       <= pat_d;
      oVSYNC      <= vsync_d;
      oDE         <= de_d;
      oBUSY       <= busy_d;
      oFRAME_DONE <= done_d;
      oFRAME_CNT  <= fcnt_d;
      oDATA_L     <= data_l_d;
      oDATA_R     <= data_r_d;
    end
  end

  assign oHSYNC = oDE;

endmodule

// File: doc/cl_tx_gen.md
CL_TX_GEN -- requirements
Module: cl_tx_gen

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, bits per pixel on each tap.
REQ-002 Parameter ADDR_WIDTH, default 11, width of size, blanking and counter fields.
REQ-003 CCLK  in  1  single clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iENABLE  in  1  start frames while high; on deassert, the current frame completes.
REQ-006 iHSIZE  in  ADDR_WIDTH  pixels per line; LSB ignored (two pixels per clock).
REQ-007 iVSIZE  in  ADDR_WIDTH  lines per frame.
REQ-008 iHBLANK  in  ADDR_WIDTH  pre-line blanking cycles with oVSYNC high.
REQ-009 iVBLANK  in  ADDR_WIDTH  inter-frame cycles with oVSYNC low.
REQ-010 iPATTERN_SEL  in  2  test pattern select.
REQ-011 iCONST  in  PIXEL_WIDTH  constant pixel value for pattern 3.
REQ-012 oVSYNC  out  1  frame valid.
REQ-013 oHSYNC  out  1  line valid; identical to oDE.
REQ-014 oDE  out  1  pixel pair valid.
REQ-015 oDATA_L  out  PIXEL_WIDTH  even-column pixel.
REQ-016 oDATA_R  out  PIXEL_WIDTH  odd-column pixel.
REQ-017 oFRAME_DONE  out  1  one-cycle pulse at end of each frame.
REQ-018 oFRAME_CNT  out  ADDR_WIDTH  completed frames, wraps modulo 2^ADDR_WIDTH.
REQ-019 oBUSY  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, HBLANK, ACTIVE, VBLANK; all outputs registered.
REQ-021 Size check: sizes are valid when iHSIZE[ADDR_WIDTH-1:1] != 0 and iVSIZE != 0.
REQ-022 IDLE exit: from IDLE with iENABLE=1 and valid sizes, the FSM moves to HBLANK; oVSYNC=1 on the following cycle.
REQ-023 Frame start latch: iHSIZE, iVSIZE, iHBLANK, iVBLANK and iPATTERN_SEL are latched on every transition into the first HBLANK of a frame; input changes mid-frame have no effect.
REQ-024 HBLANK: lasts max(iHBLANK,1) cycles; oVSYNC=1, oDE=0, oHSYNC=0.
REQ-025 ACTIVE: lasts hsize/2 cycles; oVSYNC=1, oDE=oHSYNC=1.
REQ-026 Column/row: the column index starts at 0 and advances by 2 per ACTIVE cycle; the row index starts at 0 and increments at the end of each line.
REQ-027 End of line, not last: after ACTIVE of row < vsize-1, the FSM returns to HBLANK.
REQ-028 End of last line: after ACTIVE of the last row, the FSM enters VBLANK.
REQ-029 VBLANK entry: on entering VBLANK, oFRAME_DONE pulses 1 cycle and oFRAME_CNT increments in the same cycle.
REQ-030 VBLANK: lasts max(iVBLANK,1) cycles with oVSYNC=oDE=0.
REQ-031 VBLANK exit: goes to HBLANK (new frame) if iENABLE=1 and sizes are valid, else IDLE.
REQ-032 Pattern 0 (horizontal ramp): oDATA_L=col[PIXEL_WIDTH-1:0], oDATA_R=(col+1)[PIXEL_WIDTH-1:0].
REQ-033 Pattern 1 (vertical ramp): oDATA_L=oDATA_R=row[PIXEL_WIDTH-1:0].
REQ-034 Pattern 2 (checkerboard): both taps are all-ones if col[3]^row[3]=1, else zero.
REQ-035 Pattern 3 (constant): both taps are iCONST, sampled live.
REQ-036 Data blanking: oDATA_L and oDATA_R are 0 whenever oDE=0.
REQ-037 Minimum spacing: at least one cycle of oVSYNC=1, oDE=0 precedes the first oDE of each frame, so downstream edge detectors see distinct FVAL and DVAL rises.
REQ-038 Invalid sizes: the FSM stays in IDLE with all outputs low except oFRAME_CNT.

Reset
REQ-039 With RST=1 at a clock edge: next cycle state=IDLE and all outputs, including oFRAME_CNT, are 0.
REQ-040 RST mid-frame aborts the frame without an oFRAME_DONE pulse or oFRAME_CNT increment.

Verification
REQ-041 Basic frame: HSIZE=8, VSIZE=2, HBLANK=2, VBLANK=3, pattern 0, iENABLE held -> oVSYNC high 12 cycles; oDE bursts of 4; first line L=0,2,4,6 and R=1,3,5,7; oFRAME_DONE pulse; oVSYNC low 3 cycles; next frame starts.
REQ-042 Zero blanking: HBLANK=0, VBLANK=0 -> treated as 1; oVSYNC rises exactly 1 cycle before first oDE; 1-cycle gap between frames.
REQ-043 Enable drop: iENABLE cleared mid-line 1 of 3 -> frame completes all 3 lines, oFRAME_CNT +1, then IDLE with oBUSY=0.
REQ-044 Mid-frame change: iHSIZE changed 16->32 mid-frame -> current frame keeps 8-cycle oDE bursts; next frame uses 16-cycle bursts.
REQ-045 Reset abort: RST asserted during ACTIVE, pattern 2 -> next cycle all outputs 0, oFRAME_CNT=0; after release with iENABLE=1, a fresh frame starts with row 0.
REQ-046 Counter wrap and invalid sizes: oFRAME_CNT wraps from 2047 to 0; iVSIZE=0 -> oBUSY stays 0 and no oVSYNC activity.
